// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampled UART receiver with parity/stop checking and a valid/ready byte output.
module uart_rx_core #(
  parameter int DATA_W  = 8,
  parameter int OS_RATE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baud_sample,
  input  logic              rx_en,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              uart_rxd,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_parity_err,
  output logic              rx_frame_err,
  output logic              rx_overrun,
  output logic              rx_busy
);
  localparam int TW = $clog2(OS_RATE);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAITHI} state_e;
  state_e            state_q;
  logic [TW-1:0]     tick_q;
  logic [2:0]        bit_q;
  logic [DATA_W-1:0] shift_q, rx_data_q;
  logic              rxd_m_q, rxd_s_q;
  logic              perr_q, ferr_q, done_q;
  logic              rx_valid_q, rx_perr_q, rx_ferr_q, rx_ovr_q;
  logic              tick_mid, tick_end, accept;
  assign tick_mid = tick_q == TW'(OS_RATE / 2 - 1);
  assign tick_end = tick_q == TW'(OS_RATE - 1);
  // a finished frame may load when the holding slot is empty or being drained this same clk
  assign accept   = done_q && (!rx_valid_q || rx_ready);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      rxd_m_q    <= 1'b1;
      rxd_s_q    <= 1'b1;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rxd_m_q <= uart_rxd;
      rxd_s_q <= rxd_m_q;
      done_q  <= 1'b0;
      if (!rx_en) begin
        state_q <= IDLE;
        tick_q  <= '0;
      end else if (baud_sample) begin
        tick_q <= tick_q + TW'(1);
        case (state_q)
          IDLE: if (!rxd_s_q) begin
            state_q <= START;
            tick_q  <= '0;
          end
          START: if (tick_mid) begin
            if (rxd_s_q) state_q <= IDLE;
            else begin
              state_q <= DATA;
              tick_q  <= '0;
              bit_q   <= '0;
              perr_q  <= 1'b0;
            end
          end
          DATA: if (tick_end) begin
            shift_q <= {rxd_s_q, shift_q[DATA_W-1:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'(DATA_W - 1)) state_q <= parity_en ? PARITY : STOP;
          end
          PARITY: if (tick_end) begin
            perr_q  <= rxd_s_q ^ (^shift_q) ^ parity_odd;
            state_q <= STOP;
          end
          STOP: if (tick_end) begin
            done_q  <= 1'b1;
            ferr_q  <= !rxd_s_q;
            state_q <= rxd_s_q ? IDLE : WAITHI;
          end
          WAITHI: if (rxd_s_q) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
      if (accept) begin
        rx_data_q  <= shift_q;
        rx_perr_q  <= perr_q;
        rx_ferr_q  <= ferr_q;
        rx_valid_q <= 1'b1;
      end else if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
      rx_ovr_q <= done_q && !accept;
    end
  end
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_overrun    = rx_ovr_q;
  assign rx_busy       = state_q != IDLE;
endmodule
